// File: rtl/vco_phase_quantizer.sv
// VCO-ADC back end: syncs/decodes ring phase, accumulates per-clk phase advance over an OSR window.
// p->s takes 3 edges; sample held until ready, a window end while unaccepted overwrites it and sets overflow.
module vco_phase_quantizer #(
    parameter int PHASE_WIDTH = 11,
    parameter int OSR_WIDTH   = 10,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enb,
    input  logic [PHASE_WIDTH-1:0] p,
    input  logic [OSR_WIDTH-1:0]   osr,
    output logic [OUT_WIDTH-1:0]   sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic                   bubble_err
);

    localparam int NST = 2 * PHASE_WIDTH;
    localparam int SW  = $clog2(NST);
    localparam int CW  = $clog2(PHASE_WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] p_meta_q, p_s_q;
    logic [SW-1:0]          s_q, s_d, s_prev_q;
    logic                   bubble_q, bubble_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d, data_q, data_d;
    logic [OSR_WIDTH-1:0]   win_q, win_d, osr_l_q, osr_l_d;
    logic                   valid_q, valid_d, ovf_q, ovf_d;

    logic [CW-1:0]          pc;
    logic [SW-1:0]          cand, d_w;
    logic [PHASE_WIDTH-1:0] pat;
    logic [OUT_WIDTH:0]     sum_w;
    logic [OUT_WIDTH-1:0]   sat_w;
    logic [OSR_WIDTH-1:0]   osr_eff;
    logic                   win_end, run_active, start, ovf_set;

    // Ring decode: popcount gives the state, then the state is re-encoded to reject bubbles
    always_comb begin
        pc = '0;
        for (int i = 0; i < PHASE_WIDTH; i++) begin
            pc = pc + CW'(p_s_q[i]);
        end
        if (p_s_q[0])     cand = SW'(pc);
        else if (pc == 0) cand = '0;
        else              cand = SW'(NST) - SW'(pc);
        pat = '0;
        for (int i = 0; i < PHASE_WIDTH; i++) begin
            if (int'(cand) < PHASE_WIDTH) pat[i] = (i < int'(cand));
            else                          pat[i] = (i >= int'(cand) - PHASE_WIDTH);
        end
        bubble_d = (pat != p_s_q);
        s_d      = bubble_d ? s_q : cand;
    end

    always_comb begin
        if (s_q >= s_prev_q) d_w = s_q - s_prev_q;
        else                 d_w = s_q + (SW'(NST) - s_prev_q);
        sum_w   = {1'b0, acc_q} + (OUT_WIDTH + 1)'(d_w);
        sat_w   = sum_w[OUT_WIDTH] ? '1 : sum_w[OUT_WIDTH-1:0];
        osr_eff = (osr == '0) ? OSR_WIDTH'(1) : osr;
        win_end = (win_q == osr_l_q - OSR_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!enb) state_d = RUN;
            RUN:     if (enb)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run_active = (state_q == RUN) && !enb;
        start      = (state_q == IDLE) && !enb;
    end

    // Leaving RUN discards the partial window: no window end is honoured once enb is high
    always_comb begin
        acc_d   = acc_q;
        win_d   = win_q;
        osr_l_d = osr_l_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_set = 1'b0;
        if (!run_active) begin
            acc_d   = '0;
            win_d   = '0;
            valid_d = 1'b0;
            if (start) osr_l_d = osr_eff;
        end else if (win_end) begin
            data_d  = sat_w;
            valid_d = 1'b1;
            acc_d   = '0;
            win_d   = '0;
            osr_l_d = osr_eff;
            ovf_set = valid_q && !sample_ready;
        end else begin
            acc_d = sat_w;
            win_d = win_q + OSR_WIDTH'(1);
            if (valid_q && sample_ready) valid_d = 1'b0;
        end
        if (clr_ovf)      ovf_d = 1'b0;
        else if (ovf_set) ovf_d = 1'b1;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_meta_q <= '0;
            p_s_q    <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
            bubble_q <= 1'b0;
            acc_q    <= '0;
            win_q    <= '0;
            osr_l_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            p_meta_q <= p;
            p_s_q    <= p_meta_q;
            s_q      <= s_d;
            s_prev_q <= s_q;
            bubble_q <= bubble_d;
            acc_q    <= acc_d;
            win_q    <= win_d;
            osr_l_q  <= osr_l_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overflow     = ovf_q;
    assign bubble_err   = bubble_q;

endmodule

// File: tb/tb_vco_phase_quantizer.sv
// Scoreboard bench for vco_phase_quantizer: expected samples queued at stimulus, popped on handshake.
module tb_vco_phase_quantizer;

    localparam int N = 11;

    logic        clk = 1'b0;
    logic        rst, enb, sample_ready, clr_ovf;
    logic [10:0] p;
    logic [9:0]  osr;
    logic [15:0] sample_data;
    logic        sample_valid, overflow, bubble_err;

    int n_chk = 0, n_err = 0;
    int acc_cnt = 0, cyc_cnt = 0, last_acc = 0, prev_acc = 0;
    int bub_cnt = 0, bub_long = 0, bub0 = 0, tgt = 0, exp_v = 0;
    bit bub_prev = 1'b0;
    int exp_q[$];
    int cur_s = 0, step = 0;

    vco_phase_quantizer dut (
        .clk(clk), .rst(rst), .enb(enb), .p(p), .osr(osr),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overflow(overflow),
        .clr_ovf(clr_ovf), .bubble_err(bubble_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_val);
        n_chk++;
        if (obs !== exp_val) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp_val);
        end
    endtask

    function automatic logic [10:0] ring_pat(input int s);
        logic [10:0] r;
        for (int i = 0; i < N; i++) r[i] = (s < N) ? (i < s) : (i >= s - N);
        return r;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Sampled mid-cycle: a valid&ready seen here completes at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bubble_err) begin
                bub_cnt++;
                if (bub_prev) bub_long++;
            end
            bub_prev = bubble_err;
            if (sample_valid && sample_ready) begin
                acc_cnt++;
                prev_acc = last_acc;
                last_acc = cyc_cnt;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", int'(sample_data), -1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sample_data", int'(sample_data), exp_v);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (step != 0) begin
                cur_s = (cur_s + step) % (2 * N);
                p     = ring_pat(cur_s);
            end
        end
    endtask

    task automatic wait_for(input int target, input int budget);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            cyc(1);
            k++;
        end
        if (acc_cnt < target) check("sample_timeout", acc_cnt, target);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; p = '0; osr = 10'd4; sample_ready = 1'b1; clr_ovf = 1'b0;
        #12;
        check("rst_data", int'(sample_data), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_bubble", int'(bubble_err), 0);

        // constant phase, osr=4
        repeat (4) exp_q.push_back(0);
        @(posedge clk); #1; rst = 1'b0;
        wait_for(acc_cnt + 4, 40);
        sample_ready = 1'b0; enb = 1'b1;
        check("t1_period", last_acc - prev_acc, 4);
        check("t1_no_bubble", bub_cnt, 0);

        // +1 ring state per clk, osr=8
        cur_s = 0; step = 1;
        cyc(5);
        osr = 10'd8;
        repeat (3) exp_q.push_back(8);
        enb = 1'b0; sample_ready = 1'b1;
        wait_for(acc_cnt + 3, 60);
        sample_ready = 1'b0; enb = 1'b1;

        // wrap 21 -> 1 in one clk, osr=1
        step = 0; cur_s = 21; p = ring_pat(21);
        cyc(5);
        osr = 10'd1; cur_s = 1; p = ring_pat(1);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
        enb = 1'b0; sample_ready = 1'b1;
        wait_for(acc_cnt + 4, 20);
        sample_ready = 1'b0; enb = 1'b1;

        // overflow across two unaccepted window ends
        step = 1; osr = 10'd4; clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        cyc(3);
        check("t4_ovf_before", int'(overflow), 0);
        enb = 1'b0;
        cyc(10);
        check("t4_ovf_set", int'(overflow), 1);
        check("t4_valid_held", int'(sample_valid), 1);
        exp_q.push_back(4);
        sample_ready = 1'b1;
        wait_for(acc_cnt + 1, 10);
        sample_ready = 1'b0; enb = 1'b1;
        cyc(2);
        check("t4_ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        check("t4_ovf_clr", int'(overflow), 0);

        // enb pulse drops pending sample and partial window; osr change waits for boundary
        osr = 10'd8; enb = 1'b0;
        cyc(10);
        check("t5_valid_pending", int'(sample_valid), 1);
        enb = 1'b1;
        cyc(3);
        check("t5_valid_dropped", int'(sample_valid), 0);
        exp_q.push_back(8); exp_q.push_back(2);
        enb = 1'b0; sample_ready = 1'b1;
        cyc(1);
        osr = 10'd2;
        wait_for(acc_cnt + 2, 40);
        sample_ready = 1'b0;
        cyc(12);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_data", int'(sample_data), 0);
        check("t5_rst_valid", int'(sample_valid), 0);
        check("t5_rst_ovf", int'(overflow), 0);
        check("t5_rst_bubble", int'(bubble_err), 0);
        @(posedge clk); #1; rst = 1'b0; enb = 1'b1;

        // illegal phase pattern for one clk
        step = 0; cur_s = 5; p = ring_pat(5); osr = 10'd1;
        cyc(5);
        bub0 = bub_cnt; bub_long = 0;
        repeat (8) exp_q.push_back(0);
        tgt = acc_cnt + 8;
        enb = 1'b0; sample_ready = 1'b1;
        cyc(2);
        p = 11'b000_0000_0101;
        cyc(1);
        p = ring_pat(5);
        wait_for(tgt, 30);
        sample_ready = 1'b0; enb = 1'b1;
        cyc(3);
        check("t6_bubble_pulses", bub_cnt - bub0, 1);
        check("t6_bubble_width", bub_long, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
